// File: rtl/reg_cfg_pkg.sv
// Shared types and constants for the register-bus initiator.
package reg_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

  localparam int DEFAULT_TIMEOUT = 16;

  // Wide enough to hold TIMEOUT itself, so the counter never wraps early.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/reg_cfg_master_if.sv
// Host command/response channels plus the switch register bus, viewed from
// the initiator (master) or from the host/register-top side (slave).
interface reg_cfg_master_if #(
  parameter int W_WIDTH = 8
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_wr;
  logic [W_WIDTH-1:0] cmd_addr;
  logic [W_WIDTH-1:0] cmd_wdata;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [W_WIDTH-1:0] rsp_rdata;
  logic               rsp_err;

  logic               sel_en;
  logic               wr_rd_s;
  logic [W_WIDTH-1:0] addr;
  logic [W_WIDTH-1:0] wr_data;
  logic [W_WIDTH-1:0] rd_data;
  logic               ack;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rd_data, ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel_en, wr_rd_s, addr, wr_data
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rd_data, ack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel_en, wr_rd_s, addr, wr_data
  );

endinterface

// File: rtl/reg_cfg_master.sv
// Register-bus initiator: one host command at a time, bus access starts the cycle after acceptance.
// cmd_ready only in IDLE; response held until rsp_ready. REG_CFG_MASTER_ADDR_CHECK_EN rejects addr >= NUM_OF_REG.
module reg_cfg_master
  import reg_cfg_pkg::*;
#(
  parameter int NUM_OF_REG = 4,
  parameter int W_WIDTH    = 8,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  reg_cfg_master_if.master   cfg
);

  localparam int                CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [W_WIDTH:0]  NREG     = (W_WIDTH + 1)'(NUM_OF_REG);

`ifdef REG_CFG_MASTER_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  state_e             state_q,     state_d;
  logic [CW-1:0]      cnt_q,       cnt_d;
  logic               sel_en_q,    sel_en_d;
  logic               wr_rd_s_q,   wr_rd_s_d;
  logic [W_WIDTH-1:0] addr_q,      addr_d;
  logic [W_WIDTH-1:0] wr_data_q,   wr_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [W_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q,   rsp_err_d;

  logic addr_err;

  assign addr_err = ADDR_CHECK && ({1'b0, cfg.cmd_addr} >= NREG);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_en_d    = sel_en_q;
    wr_rd_s_d   = wr_rd_s_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cfg.cmd_valid) begin
          cnt_d = '0;
          if (addr_err) begin
            // Rejected commands never touch the bus; answer straight away.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d   = ACCESS;
            sel_en_d  = 1'b1;
            wr_rd_s_d = cfg.cmd_wr;
            addr_d    = cfg.cmd_addr;
            wr_data_d = cfg.cmd_wdata;
          end
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cfg.ack) begin
          // ack in the final allowed cycle still counts as success.
          state_d     = RESP;
          sel_en_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = (wr_rd_s_q == DIR_WR) ? '0 : cfg.rd_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          sel_en_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end

      RESP: begin
        if (cfg.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_en_q    <= 1'b0;
      wr_rd_s_q   <= DIR_RD;
      addr_q      <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_en_q    <= sel_en_d;
      wr_rd_s_q   <= wr_rd_s_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cfg.cmd_ready = (state_q == IDLE);
  assign cfg.sel_en    = sel_en_q;
  assign cfg.wr_rd_s   = wr_rd_s_q;
  assign cfg.addr      = addr_q;
  assign cfg.wr_data   = wr_data_q;
  assign cfg.rsp_valid = rsp_valid_q;
  assign cfg.rsp_rdata = rsp_rdata_q;
  assign cfg.rsp_err   = rsp_err_q;

endmodule

// File: doc/reg_cfg_master.md
Name: reg_cfg_master

Overview:
- Initiator for the switch register-access interface (sel_en / wr_rd_s / addr / wr_data / rd_data / ack).
- Takes single read/write commands from a host-side valid/ready channel and runs them on the register bus.
- Returns read data and status on a response channel.
- Sits between the host/test controller and the switch's register top; drives that block's bus inputs and consumes its rd_data/ack.

Parameters:
- NUM_OF_REG, 4, number of implemented registers; used by the optional address check.
- W_WIDTH, 8, width of addr, wr_data, rd_data and the command/response data fields.
- TIMEOUT, 16, maximum number of cycles sel_en stays high waiting for ack (>=1).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  master accepts a command (IDLE only).
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  W_WIDTH  target register address.
- cmd_wdata  in  W_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host consumes the response.
- rsp_rdata  out  W_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  transaction failed (timeout, or address error when enabled).
- sel_en  out  1  bus select, held high for the whole access.
- wr_rd_s  out  1  bus direction: 1 = write, 0 = read.
- addr  out  W_WIDTH  bus address.
- wr_data  out  W_WIDTH  bus write data.
- rd_data  in  W_WIDTH  bus read data; valid in the cycle ack is high.
- ack  in  1  bus completion strobe.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - Outputs: sel_en=0, wr_rd_s=0, addr=0, wr_data=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=1 from the first cycle after reset.
  - Timeout counter = 0.
  - Reset mid-access drops sel_en the next cycle and discards any pending response.
- Outputs are registered except cmd_ready, which is decoded from the state.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, capture cmd_wr/addr/wdata into wr_rd_s/addr/wr_data, set sel_en=1, counter=0, go to ACCESS.
  - The first bus cycle is the cycle after acceptance.
- ACCESS:
  - sel_en=1; wr_rd_s/addr/wr_data held stable; cmd_ready=0.
  - Counter increments each cycle.
  - ack sampled high: sel_en=0; rsp_rdata = rd_data if read, else 0; rsp_err=0; rsp_valid=1 next cycle; go to RESP.
  - No ack and counter reaches TIMEOUT-1 (sel_en has been high for TIMEOUT cycles): sel_en=0, rsp_err=1, rsp_rdata=0, go to RESP.
  - ack in that same final cycle: ack wins, no error.
- RESP:
  - rsp_valid=1 and rsp_* held stable until rsp_ready; sel_en=0.
  - On rsp_valid&rsp_ready: rsp_valid=0, go to IDLE.
  - A new command can be accepted in the following cycle, so sel_en is low for at least 2 cycles between accesses.
  - ack arriving outside ACCESS is ignored.
- Latency with zero-wait ack and rsp_ready tied high: command accepted at cycle N, sel_en high at N+1, response valid at N+2, next command accepted at N+3.
- Exactly one transaction is outstanding at a time; there is no command buffering.

Optional Feature:
- Macro: REG_CFG_MASTER_ADDR_CHECK_EN.
- Defined:
  - A command with cmd_addr >= NUM_OF_REG is accepted but never reaches the bus (sel_en stays 0).
  - Goes IDLE -> RESP directly with rsp_err=1, rsp_rdata=0; rsp_valid high the cycle after acceptance.
- Undefined: every address is issued on the bus; out-of-range accesses rely on the bus ack or the timeout.

Decomposition:
- Shared package reg_cfg_pkg:
  - State enum: IDLE, ACCESS, RESP.
  - Localparams: direction encodings (WR=1, RD=0); timeout counter width = $clog2(TIMEOUT+1).
- No sub-module needed.
- The timeout counter stays inline; a separate counter instance is not warranted at this size.

Test Plan:
- Write then read: write cmd addr=2 wdata=0xA5 against the register top (ack 1 cycle later) -> bus shows sel_en=1, wr_rd_s=1, addr=2, wr_data=0xA5; response err=0, rdata=0. Then read addr=2 -> rsp_rdata=0xA5, err=0.
- Timing: back-to-back reads of addr 0..3 with rsp_ready=1 -> sel_en has a low gap of at least 2 cycles between accesses; cmd_ready is low from acceptance until the cycle after the response handshake.
- Timeout: stub never acks, TIMEOUT=16 -> sel_en high exactly 16 cycles, then rsp_err=1, rsp_rdata=0. Repeat with ack on the 16th cycle and rd_data=0x3C -> err=0, rdata=0x3C.
- Backpressure: rsp_ready held low 5 cycles after a read of 0x5A -> rsp_valid and rsp_rdata=0x5A stable throughout; cmd_valid held high is not accepted until after the handshake.
- Reset mid-operation: rst asserted in ACCESS cycle 3 -> next cycle sel_en=0, rsp_valid=0, cmd_ready=1; a stray late ack produces no response.
- Address check (REG_CFG_MASTER_ADDR_CHECK_EN defined): read addr=7 with NUM_OF_REG=4 -> sel_en never rises; rsp_err=1 one cycle after acceptance. Same stimulus with the macro undefined -> bus access issued.
